mips_mc_control: RTL

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control_pkg.sv | 41 ++++
 rtl/mips_mc_control.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcodes and the ALU operation / operand-select codes.
package MipsCtrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIMM = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_control.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode only the
// registered state (plus mem_ready gating of the FETCH instruction write).
module mips_mc_control
    import MipsCtrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Unreachable encodings fall through to the default and recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_REG;
        pcsrc       = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = SRCB_SHIMM;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsrc       = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
